multi_channel_scale_calculator: RTL and testbench

Per-channel reciprocal quantization-scale engine. For each channel it computes reciprocal_scale = (QMAX << FRAC_BITS) / max_abs as an unsigned fixed-point quotient, with truncating or round-to-nearest mode. It generalises the single-channel fixed-radix scale calculator: width, fraction bits, channel count and steps per cycle are parameters; input and output use valid/ready; and the last result per channel is kept in a readable table. It sits between the per-channel max-abs reduction and the requantization multipliers.

---
 rtl/multi_channel_scale_calculator_pkg.sv | 22 ++
 rtl/multi_channel_scale_calculator_div_step.sv | 27 ++
 rtl/multi_channel_scale_calculator.sv | 218 +++++++++++++++++++++
 tb/tb_multi_channel_scale_calculator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_scale_calculator_pkg.sv
// Shared types and elaboration-time helpers for the per-channel reciprocal scale engine.
package scale_calc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Dividend of the reciprocal: QMAX scaled up by the number of fraction bits.
    function automatic logic [63:0] calc_dividend(input int unsigned qmax,
                                                  input int unsigned frac_bits);
        return 64'(qmax) << frac_bits;
    endfunction

    // Number of DIV cycles needed to retire all quotient bits.
    function automatic int unsigned calc_cycles(input int unsigned data_w,
                                                input int unsigned steps);
        return data_w / steps;
    endfunction

endpackage

// File: rtl/multi_channel_scale_calculator_div_step.sv
// One combinational restoring-division step: shift {rem, quo} left and conditionally subtract.
module scale_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_div,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_shift;
    logic            w_ge;

    // Shifted partial remainder needs one extra bit so large divisors compare correctly.
    always_comb begin
        w_shift = {i_rem, i_quo[DATA_W-1]};
        w_ge    = (w_shift >= {1'b0, i_div});
        if (w_ge) begin
            o_rem = DATA_W'(w_shift - {1'b0, i_div});
        end else begin
            o_rem = w_shift[DATA_W-1:0];
        end
        o_quo = {i_quo[DATA_W-2:0], w_ge};
    end

endmodule

// File: rtl/multi_channel_scale_calculator.sv
// Per-channel reciprocal quantization-scale engine with a one-deep output register
// and a readable table holding the last result of every channel.
module multi_channel_scale_calculator
    import scale_calc_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int FRAC_BITS       = 24,
    parameter int QMAX            = 127,
    parameter int NUM_CH          = 4,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_max_abs,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_scale,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_div_zero,
    output logic              busy,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_scale,
    output logic [NUM_CH-1:0] tbl_valid
);

    localparam logic [63:0]       DIV64    = calc_dividend(QMAX, FRAC_BITS);
    localparam logic [DATA_W-1:0] DIVIDEND = DATA_W'(DIV64);
    localparam int                N_CYC    = int'(calc_cycles(DATA_W, STEPS_PER_CYCLE));
    localparam int                CNT_W    = $clog2(N_CYC) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_CYC - 1);
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};

    if (DIV64 >= ((64'd1 << DATA_W) - 64'd1)) begin : g_bad_range
        $error("QMAX << FRAC_BITS does not fit below 2^DATA_W - 1");
    end
    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4) ||
        (DATA_W % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
        $error("STEPS_PER_CYCLE must be 1, 2 or 4 and divide DATA_W");
    end

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic [CH_W-1:0]   r_ch;
    logic              r_round;
    logic [DATA_W-1:0] r_pend_scale;
    logic              r_pend_dz;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_scale;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_dz;
    logic [DATA_W-1:0] r_tbl [NUM_CH];
    logic [NUM_CH-1:0] r_tbl_valid;
    logic [DATA_W-1:0] r_rd_scale;

    logic [DATA_W-1:0] w_rem [0:STEPS_PER_CYCLE];
    logic [DATA_W-1:0] w_quo [0:STEPS_PER_CYCLE];
    logic [DATA_W-1:0] w_quo_rnd;
    logic              w_final;
    logic              w_out_free;
    logic              w_load;
    logic [DATA_W-1:0] w_load_scale;
    logic              w_load_dz;
    logic              w_ch_ok;
    logic              w_rd_ok;

    assign w_rem[0] = r_rem;
    assign w_quo[0] = r_quo;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        scale_div_step #(.DATA_W(DATA_W)) u_step (
            .i_rem (w_rem[g]),
            .i_quo (w_quo[g]),
            .i_div (r_div),
            .o_rem (w_rem[g+1]),
            .o_quo (w_quo[g+1])
        );
    end

    // Final-cycle rounding, output-register handshake and load selection.
    always_comb begin
        w_quo_rnd = w_quo[STEPS_PER_CYCLE];
        if (r_round && ({w_rem[STEPS_PER_CYCLE], 1'b0} >= {1'b0, r_div})) begin
            if (&w_quo[STEPS_PER_CYCLE]) begin
                w_quo_rnd = w_quo[STEPS_PER_CYCLE];
            end else begin
                w_quo_rnd = w_quo[STEPS_PER_CYCLE] + ONE;
            end
        end else begin
            w_quo_rnd = w_quo[STEPS_PER_CYCLE];
        end
        w_final    = (r_state == S_DIV) && (r_cnt == CNT_LAST);
        w_out_free = !r_out_valid || out_ready;
        w_load     = (w_final || (r_state == S_WAIT)) && w_out_free;
        if (r_state == S_WAIT) begin
            w_load_scale = r_pend_scale;
            w_load_dz    = r_pend_dz;
        end else begin
            w_load_scale = w_quo_rnd;
            w_load_dz    = 1'b0;
        end
        w_ch_ok = ({1'b0, r_ch} < NUM_CH_L);
        w_rd_ok = ({1'b0, rd_ch} < NUM_CH_L);
    end

    // Control FSM, division datapath registers and the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_rem        <= ZERO;
            r_quo        <= ZERO;
            r_div        <= ZERO;
            r_ch         <= {CH_W{1'b0}};
            r_round      <= 1'b0;
            r_pend_scale <= ZERO;
            r_pend_dz    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_scale  <= ZERO;
            r_out_ch     <= {CH_W{1'b0}};
            r_out_dz     <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_scale <= w_load_scale;
                r_out_ch    <= r_ch;
                r_out_dz    <= w_load_dz;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_div   <= in_max_abs;
                        r_ch    <= in_ch;
                        r_round <= in_round;
                        r_rem   <= ZERO;
                        r_quo   <= DIVIDEND;
                        r_cnt   <= {CNT_W{1'b0}};
                        if (in_max_abs == ZERO) begin
                            r_pend_scale <= ZERO;
                            r_pend_dz    <= 1'b1;
                            r_state      <= S_WAIT;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem[STEPS_PER_CYCLE];
                    r_quo <= w_quo[STEPS_PER_CYCLE];
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (w_final) begin
                        if (w_out_free) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_pend_scale <= w_quo_rnd;
                            r_pend_dz    <= 1'b0;
                            r_state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_out_free) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result table: written whenever the output register loads an in-range channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_tbl[c] <= ZERO;
            end
            r_tbl_valid <= {NUM_CH{1'b0}};
        end else if (w_load && w_ch_ok) begin
            r_tbl[r_ch]       <= w_load_scale;
            r_tbl_valid[r_ch] <= 1'b1;
        end
    end

    // Registered table read; a same-cycle write to the same entry returns the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_scale <= ZERO;
        end else if (w_rd_ok) begin
            r_rd_scale <= r_tbl[rd_ch];
        end else begin
            r_rd_scale <= ZERO;
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = r_out_valid;
    assign out_scale    = r_out_scale;
    assign out_ch       = r_out_ch;
    assign out_div_zero = r_out_dz;
    assign busy         = (r_state != S_IDLE) || r_out_valid;
    assign rd_scale     = r_rd_scale;
    assign tbl_valid    = r_tbl_valid;

endmodule

// File: tb/tb_multi_channel_scale_calculator.sv
// Randomized self-checking bench for multi_channel_scale_calculator against an arithmetic model.
module tb_multi_channel_scale_calculator;

    localparam logic [63:0] DIVIDEND = 64'd127 << 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_max_abs = 32'd0;
    logic [1:0]  in_ch = 2'd0;
    logic        in_round = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_scale;
    logic [1:0]  out_ch;
    logic        out_div_zero;
    logic        busy;
    logic [1:0]  rd_ch = 2'd0;
    logic [31:0] rd_scale;
    logic [3:0]  tbl_valid;

    logic        v4 = 1'b0;
    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_scale4;
    logic [1:0]  out_ch4;
    logic        out_dz4;
    logic        busy4;
    logic [31:0] rd_scale4;
    logic [3:0]  tbl_valid4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] model_tbl [4];
    logic [3:0]  model_mask;

    always #5 clk = ~clk;

    multi_channel_scale_calculator u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_max_abs(in_max_abs),
        .in_ch(in_ch), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_scale(out_scale),
        .out_ch(out_ch), .out_div_zero(out_div_zero), .busy(busy),
        .rd_ch(rd_ch), .rd_scale(rd_scale), .tbl_valid(tbl_valid)
    );

    multi_channel_scale_calculator #(.STEPS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v4), .in_ready(in_ready4), .in_max_abs(32'd127),
        .in_ch(2'd0), .in_round(1'b0),
        .out_valid(out_valid4), .out_ready(1'b1), .out_scale(out_scale4),
        .out_ch(out_ch4), .out_div_zero(out_dz4), .busy(busy4),
        .rd_ch(2'd0), .rd_scale(rd_scale4), .tbl_valid(tbl_valid4)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_scale(input logic [31:0] d, input logic rnd);
        logic [63:0] q;
        logic [63:0] r;
        if (d == 32'd0) return 64'd0;
        q = DIVIDEND / 64'(d);
        r = DIVIDEND % 64'(d);
        if (rnd && (2 * r >= 64'(d))) q = q + 64'd1;
        if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
        return q;
    endfunction

    task automatic send(input logic [31:0] d, input logic [1:0] ch, input logic rnd);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_max_abs = d;
        in_ch      = ch;
        in_round   = rnd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
        if (lat >= 200) check_val("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic model_write(input logic [1:0] ch, input logic [63:0] s);
        model_tbl[ch]  = s;
        model_mask[ch] = 1'b1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) model_tbl[c] = 64'd0;
        model_mask = 4'd0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] d, input logic [1:0] ch,
                           input logic rnd);
        int          lat;
        logic [63:0] exp;
        exp = ref_scale(d, rnd);
        send(d, ch, rnd);
        wait_out(lat);
        model_write(ch, exp);
        check_val({tag, "_scale"}, 64'(out_scale), exp);
        check_val({tag, "_ch"}, 64'(out_ch), 64'(ch));
        check_val({tag, "_dz"}, 64'(out_div_zero), 64'(d == 32'd0));
        check_val({tag, "_lat"}, 64'(lat), (d == 32'd0) ? 64'd1 : 64'd32);
        check_val({tag, "_tblv"}, 64'(tbl_valid), 64'(model_mask));
        rd_ch = ch;
        @(posedge clk);
        #1;
        check_val({tag, "_rd"}, 64'(rd_scale), model_tbl[ch]);
    endtask

    initial begin
        int          lat;
        int          sel;
        logic [31:0] d;
        logic [1:0]  ch;
        logic        rnd;
        logic        seen;

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_scale", 64'(out_scale), 64'd0);
        check_val("rst_out_ch", 64'(out_ch), 64'd0);
        check_val("rst_dz", 64'(out_div_zero), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_rd", 64'(rd_scale), 64'd0);
        check_val("rst_tblv", 64'(tbl_valid), 64'd0);
        reset_n = 1'b1;

        run_one("exact", 32'd127, 2'd1, 1'b0);
        check_val("exact_const", 64'(out_scale), 64'd16777216);
        check_val("exact_tblv_const", 64'(tbl_valid), 64'b0010);
        run_one("trunc6", 32'd6, 2'd0, 1'b0);
        check_val("trunc6_const", 64'(out_scale), 64'd355117738);
        run_one("round6", 32'd6, 2'd0, 1'b1);
        check_val("round6_const", 64'(out_scale), 64'd355117739);
        run_one("div1", 32'd1, 2'd2, 1'b0);
        check_val("div1_const", 64'(out_scale), 64'd2130706432);
        run_one("divmax", 32'hFFFF_FFFF, 2'd3, 1'b1);
        run_one("divzero", 32'd0, 2'd1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       d = 32'd0;
                1:       d = 32'($urandom_range(1, 300));
                2:       d = $urandom;
                default: d = 32'd1 << $urandom_range(0, 31);
            endcase
            ch  = 2'($urandom_range(0, 3));
            rnd = 1'($urandom_range(0, 1));
            run_one("rand", d, ch, rnd);
        end

        out_ready = 1'b0;
        send(32'd127, 2'd0, 1'b0);
        wait_out(lat);
        check_val("bp_first", 64'(out_scale), 64'd16777216);
        send(32'd3, 2'd2, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        check_val("bp_in_ready", 64'(in_ready), 64'd0);
        check_val("bp_busy", 64'(busy), 64'd1);
        check_val("bp_hold_valid", 64'(out_valid), 64'd1);
        check_val("bp_hold_scale", 64'(out_scale), 64'd16777216);
        check_val("bp_hold_ch", 64'(out_ch), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_second_valid", 64'(out_valid), 64'd1);
        check_val("bp_second_scale", 64'(out_scale), ref_scale(32'd3, 1'b0));
        check_val("bp_second_const", 64'(out_scale), 64'd710235477);
        check_val("bp_second_ch", 64'(out_ch), 64'd2);
        model_write(2'd0, 64'd16777216);
        model_write(2'd2, 64'd710235477);
        @(posedge clk);
        #1;
        check_val("bp_drained", 64'(out_valid), 64'd0);
        check_val("bp_in_ready_back", 64'(in_ready), 64'd1);

        @(negedge clk);
        v4 = 1'b1;
        @(posedge clk);
        #1;
        v4  = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid4 && lat < 200);
        check_val("s4_lat", 64'(lat), 64'd8);
        check_val("s4_scale", 64'(out_scale4), 64'd16777216);

        send(32'd5, 2'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_val("mrst_in_ready", 64'(in_ready), 64'd1);
        check_val("mrst_out_valid", 64'(out_valid), 64'd0);
        check_val("mrst_tblv", 64'(tbl_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_val("mrst_no_result", 64'(seen), 64'd0);
        rd_ch = 2'd2;
        @(posedge clk);
        #1;
        check_val("mrst_tbl_cleared", 64'(rd_scale), 64'd0);
        run_one("readback", 32'd3, 2'd2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
